// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: holds a 2-line character frame buffer and streams
// set-address commands plus character bytes to the LCD driver's byte port,
// refreshing the panel continuously with an idle gap between frames.
module lcd_frame_sequencer #(
  parameter int unsigned LINE_LEN   = 16,
  parameter int unsigned GAP_CYCLES = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrValid,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrChar,
  output logic       oWrReady,
  input  logic       iClearReq,
  output logic       oLcdWrite,
  output logic       oLcdRS,
  output logic [7:0] oLcdByte,
  input  logic       iLcdReady,
  output logic       oFrameDone
);

  localparam int unsigned BUF_LEN = 2 * LINE_LEN;
  localparam int unsigned IDX_W   = $clog2(BUF_LEN);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;
  localparam logic [7:0] SPACE     = 8'h20;

  localparam logic [IDX_W-1:0] LINE0_LAST  = IDX_W'(LINE_LEN - 1);
  localparam logic [IDX_W-1:0] LINE1_FIRST = IDX_W'(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BUF_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ADDR0,
    CHARS0,
    ADDR1,
    CHARS1,
    GAP,
    CLEAR
  } state_t;

  state_t           state, stateNext;
  logic [IDX_W-1:0] idx, idxNext, idxInc;
  logic [GAP_W-1:0] gapCnt, gapCntNext;
  logic [7:0]       frameBuf [BUF_LEN];
  logic             clearArmed, clearArmedNext;
  logic             lcdWriteNext, lcdRsNext, wrReadyNext;
  logic [7:0]       lcdByteNext;
  logic             xfer, loadSlot, clearTake, wrAccept, addrInRange;
  logic [IDX_W-1:0] wrIdx;

  // Handshake and request qualification shared by the FSM and the buffer
  always_comb begin
    xfer        = oLcdWrite && iLcdReady;
    // ADDR0 with nothing held is the reload slot after GAP, CLEAR or reset
    loadSlot    = xfer || (state == ADDR0 && !oLcdWrite);
    clearTake   = iClearReq && clearArmed && (loadSlot || state == GAP);
    wrAccept    = iWrValid && oWrReady;
    addrInRange = 32'(iWrAddr) < BUF_LEN;
    wrIdx       = IDX_W'(iWrAddr);
    idxInc      = idx + 1'b1;
  end

  // Next-state and next-output logic; the held byte only changes on a load
  always_comb begin
    stateNext      = state;
    idxNext        = idx;
    gapCntNext     = gapCnt;
    lcdWriteNext   = oLcdWrite;
    lcdRsNext      = oLcdRS;
    lcdByteNext    = oLcdByte;
    wrReadyNext    = 1'b1;
    clearArmedNext = clearArmed;

    if (!iClearReq) begin
      clearArmedNext = 1'b1;
    end

    if (clearTake) begin
      stateNext      = CLEAR;
      idxNext        = '0;
      lcdWriteNext   = 1'b0;
      wrReadyNext    = 1'b0;
      clearArmedNext = 1'b0;
    end else begin
      case (state)
        ADDR0: begin
          if (loadSlot) begin
            if (!oLcdWrite) begin
              lcdWriteNext = 1'b1;
              lcdRsNext    = 1'b0;
              lcdByteNext  = CMD_LINE0;
            end else begin
              stateNext   = CHARS0;
              idxNext     = '0;
              lcdRsNext   = 1'b1;
              lcdByteNext = frameBuf['0];
            end
          end
        end
        CHARS0: begin
          if (xfer) begin
            if (idx == LINE0_LAST) begin
              stateNext   = ADDR1;
              lcdRsNext   = 1'b0;
              lcdByteNext = CMD_LINE1;
            end else begin
              idxNext     = idxInc;
              lcdByteNext = frameBuf[idxInc];
            end
          end
        end
        ADDR1: begin
          if (xfer) begin
            stateNext   = CHARS1;
            idxNext     = LINE1_FIRST;
            lcdRsNext   = 1'b1;
            lcdByteNext = frameBuf[LINE1_FIRST];
          end
        end
        CHARS1: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              stateNext    = GAP;
              gapCntNext   = '0;
              lcdWriteNext = 1'b0;
            end else begin
              idxNext     = idxInc;
              lcdByteNext = frameBuf[idxInc];
            end
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) begin
            stateNext = ADDR0;
          end else begin
            gapCntNext = gapCnt + 1'b1;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            stateNext = ADDR0;
          end else begin
            idxNext     = idxInc;
            wrReadyNext = 1'b0;
          end
        end
        default: begin
          stateNext    = ADDR0;
          lcdWriteNext = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ADDR0;
      idx        <= '0;
      gapCnt     <= '0;
      oLcdWrite  <= 1'b0;
      oLcdRS     <= 1'b0;
      oLcdByte   <= 8'h00;
      oWrReady   <= 1'b0;
      clearArmed <= 1'b1;
    end else begin
      state      <= stateNext;
      idx        <= idxNext;
      gapCnt     <= gapCntNext;
      oLcdWrite  <= lcdWriteNext;
      oLcdRS     <= lcdRsNext;
      oLcdByte   <= lcdByteNext;
      oWrReady   <= wrReadyNext;
      clearArmed <= clearArmedNext;
    end
  end

  // Frame buffer: reset/clear fill with spaces, otherwise host writes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        frameBuf[i] <= SPACE;
      end
    end else if (state == CLEAR) begin
      frameBuf[idx] <= SPACE;
    end else if (wrAccept && addrInRange) begin
      frameBuf[wrIdx] <= iWrChar;
    end
  end

  // Frame-done must coincide with the final character's handshake
  assign oFrameDone = xfer && (state == CHARS1) && (idx == LAST_IDX);

endmodule
